// File: rtl/nem_ctrl_pkg.sv
// Shared definitions for NEM relay controllers: state encoding, one-hot helpers and default dwell times.
// Combinational helpers only; no latency and no flow control.
package nem_ctrl_pkg;

  localparam int NEM_MAX_IN        = 16;
  localparam int NEM_DEF_BREAK_CYC = 4;
  localparam int NEM_DEF_MAKE_CYC  = 8;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BREAK,
    ST_MAKE,
    ST_HOLD
  } nem_state_e;

  function automatic logic [NEM_MAX_IN-1:0] nem_onehot(input logic [3:0] idx);
    logic [NEM_MAX_IN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int unsigned nem_popcount(input logic [NEM_MAX_IN-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NEM_MAX_IN; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/nem_dwell_timer.sv
// Loadable down-counter; done pulses for one cycle on the edge that ends a loaded interval of load_val cycles.
// Load takes effect at the next edge; no backpressure.
module nem_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Seen on the last cycle of the interval, so the owner transitions exactly load_val edges after loading.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// One-hot select driver for NEM relay muxes with break-before-make dead time and make-settle before sel_valid.
// Select lands 1 cycle after accept (plus BREAK_CYC if a relay was closed); req_ready low during BREAK/MAKE.
module nem_ohmux_sel_ctrl
  import nem_ctrl_pkg::*;
#(
  parameter  int N_IN      = 2,
  parameter  int BREAK_CYC = NEM_DEF_BREAK_CYC,
  parameter  int MAKE_CYC  = NEM_DEF_MAKE_CYC,
  localparam int IW        = $clog2(N_IN),
  localparam int CW        = $clog2(((BREAK_CYC > MAKE_CYC) ? BREAK_CYC : MAKE_CYC) + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_off,
  input  logic [IW-1:0]   req_sel,
  output logic [N_IN-1:0] S,
  output logic            sel_valid,
  output logic [IW-1:0]   cur_sel,
  output logic            err
);

  nem_state_e      state, state_n;
  logic [N_IN-1:0] s_n;
  logic            sel_valid_n;
  logic [IW-1:0]   cur_sel_n;
  logic            err_n;
  logic [IW-1:0]   pend_sel, pend_sel_n;
  logic            pend_off, pend_off_n;
  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic            tmr_done;
  logic            accept;
  logic            bad_idx;
  logic [N_IN-1:0] oh_req;
  logic [N_IN-1:0] oh_pend;

  nem_dwell_timer #(.W(CW)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign req_ready = (state == ST_OFF) || (state == ST_HOLD);

  always_comb begin
    state_n     = state;
    s_n         = S;
    sel_valid_n = sel_valid;
    cur_sel_n   = cur_sel;
    err_n       = 1'b0;
    pend_sel_n  = pend_sel;
    pend_off_n  = pend_off;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    accept      = req_valid && req_ready;
    bad_idx     = !req_off && (int'(req_sel) >= N_IN);
    oh_req      = N_IN'(nem_onehot(4'(req_sel)));
    oh_pend     = N_IN'(nem_onehot(4'(pend_sel)));

    case (state)
      ST_OFF: begin
        if (accept && !req_off) begin
          if (bad_idx) begin
            err_n = 1'b1;
          end else begin
            // Nothing is closed, so the relay can be made immediately.
            s_n       = oh_req;
            cur_sel_n = req_sel;
            state_n   = ST_MAKE;
            tmr_load  = 1'b1;
            tmr_val   = CW'(MAKE_CYC);
          end
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (req_off || (!bad_idx && (req_sel != cur_sel))) begin
            s_n         = '0;
            sel_valid_n = 1'b0;
            pend_off_n  = req_off;
            pend_sel_n  = req_sel;
            state_n     = ST_BREAK;
            tmr_load    = 1'b1;
            tmr_val     = CW'(BREAK_CYC);
          end else if (bad_idx) begin
            err_n = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (tmr_done) begin
          if (pend_off) begin
            state_n = ST_OFF;
          end else begin
            s_n       = oh_pend;
            cur_sel_n = pend_sel;
            state_n   = ST_MAKE;
            tmr_load  = 1'b1;
            tmr_val   = CW'(MAKE_CYC);
          end
        end
      end
      ST_MAKE: begin
        if (tmr_done) begin
          sel_valid_n = 1'b1;
          state_n     = ST_HOLD;
        end
      end
      default: state_n = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      S         <= '0;
      sel_valid <= 1'b0;
      cur_sel   <= '0;
      err       <= 1'b0;
      pend_sel  <= '0;
      pend_off  <= 1'b0;
    end else begin
      state     <= state_n;
      S         <= s_n;
      sel_valid <= sel_valid_n;
      cur_sel   <= cur_sel_n;
      err       <= err_n;
      pend_sel  <= pend_sel_n;
      pend_off  <= pend_off_n;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst)
    nem_popcount(16'(S)) <= 1);

  // A closed select may only change by passing through all-open first.
  a_no_direct_swap: assert property (@(posedge clk) disable iff (rst)
    ((S != '0) && ($past(S) != '0)) |-> (S == $past(S)));

  a_valid_hold: assert property (@(posedge clk) disable iff (rst)
    sel_valid |-> ((S == N_IN'(nem_onehot(4'(cur_sel)))) && (state == ST_HOLD)));

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Directed and random-stream bench for nem_ohmux_sel_ctrl at N_IN=2 (dut) and N_IN=3 (dut3).
module tb_nem_ohmux_sel_ctrl;

  localparam int BRK = 4;
  localparam int MK  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid, req_off, req_sel, req_ready;
  logic [1:0] S;
  logic       sel_valid, cur_sel, err;

  logic       req3_valid, req3_off, req3_ready;
  logic [1:0] req3_sel;
  logic [2:0] S3;
  logic       sel3_valid;
  logic [1:0] cur3_sel;
  logic       err3;

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;

  nem_ohmux_sel_ctrl #(.N_IN(2), .BREAK_CYC(BRK), .MAKE_CYC(MK)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_off(req_off), .req_sel(req_sel), .S(S), .sel_valid(sel_valid),
    .cur_sel(cur_sel), .err(err)
  );

  nem_ohmux_sel_ctrl #(.N_IN(3), .BREAK_CYC(BRK), .MAKE_CYC(MK)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req3_valid), .req_ready(req3_ready),
    .req_off(req3_off), .req_sel(req3_sel), .S(S3), .sel_valid(sel3_valid),
    .cur_sel(cur3_sel), .err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req1(input logic off, input logic sel);
    req_valid = 1'b1;
    req_off   = off;
    req_sel   = sel;
    tick();
    req_valid = 1'b0;
    req_off   = 1'b0;
  endtask

  task automatic req3(input logic off, input logic [1:0] sel);
    req3_valid = 1'b1;
    req3_off   = off;
    req3_sel   = sel;
    tick();
    req3_valid = 1'b0;
    req3_off   = 1'b0;
  endtask

  // Invariant monitors: one-hot, no direct swap, dead time before re-close, sel_valid consistency.
  logic [1:0] prev2;
  int         zrun2;
  bit         seen2;
  always @(negedge clk) begin
    if (rst) begin
      prev2 = '0; zrun2 = 0; seen2 = 1'b0;
    end else begin
      if ($countones(S) > 1) viol++;
      if (S != 0 && prev2 != 0 && S != prev2) viol++;
      if (S != 0 && prev2 == 0 && seen2 && zrun2 < BRK) viol++;
      if (sel_valid && (S != (2'b01 << cur_sel) || !req_ready)) viol++;
      if (S == 0) zrun2++;
      else begin zrun2 = 0; seen2 = 1'b1; end
      prev2 = S;
    end
  end

  logic [2:0] prev3;
  int         zrun3;
  bit         seen3;
  always @(negedge clk) begin
    if (rst) begin
      prev3 = '0; zrun3 = 0; seen3 = 1'b0;
    end else begin
      if ($countones(S3) > 1) viol++;
      if (S3 != 0 && prev3 != 0 && S3 != prev3) viol++;
      if (S3 != 0 && prev3 == 0 && seen3 && zrun3 < BRK) viol++;
      if (sel3_valid && (S3 != (3'b001 << cur3_sel) || !req3_ready)) viol++;
      if (S3 == 0) zrun3++;
      else begin zrun3 = 0; seen3 = 1'b1; end
      prev3 = S3;
    end
  end

  initial begin
    logic e3;
    rst = 1'b1;
    req_valid = 1'b0; req_off = 1'b0; req_sel = 1'b0;
    req3_valid = 1'b0; req3_off = 1'b0; req3_sel = 2'd0;
    tick(); tick();
    chk("rst_S", S, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b0;
    tick();

    // OFF + off: no-op
    req1(1'b1, 1'b0);
    chk("off_noop_S", S, 0);
    chk("off_noop_ready", req_ready, 1);
    chk("off_noop_err", err, 0);

    // OFF -> select 1: immediate make, sel_valid after MK cycles
    req1(1'b0, 1'b1);
    chk("sel1_S", S, 2'b10);
    chk("sel1_ready", req_ready, 0);
    chk("sel1_valid", sel_valid, 0);
    for (int i = 1; i < MK; i++) begin
      tick();
      chk("sel1_make_ready", req_ready, 0);
      chk("sel1_make_valid", sel_valid, 0);
    end
    tick();
    chk("sel1_hold_valid", sel_valid, 1);
    chk("sel1_hold_ready", req_ready, 1);
    chk("sel1_hold_cur", cur_sel, 1);
    chk("sel1_hold_S", S, 2'b10);

    // HOLD(1) -> select 0: break then make
    req1(1'b0, 1'b0);
    chk("sw0_S", S, 0);
    chk("sw0_valid", sel_valid, 0);
    chk("sw0_ready", req_ready, 0);
    for (int i = 1; i < BRK; i++) begin
      tick();
      chk("sw0_break_S", S, 0);
    end
    tick();
    chk("sw0_make_S", S, 2'b01);
    chk("sw0_make_cur", cur_sel, 0);
    chk("sw0_make_valid", sel_valid, 0);
    for (int i = 1; i < MK; i++) begin
      tick();
      chk("sw0_make_wait", sel_valid, 0);
    end
    tick();
    chk("sw0_hold_valid", sel_valid, 1);

    // HOLD(0) + select 0: consumed, no effect
    chk("same_ready_pre", req_ready, 1);
    req1(1'b0, 1'b0);
    chk("same_S", S, 2'b01);
    chk("same_valid", sel_valid, 1);
    chk("same_ready", req_ready, 1);
    chk("same_err", err, 0);

    // Back to HOLD(1), then open all relays
    req1(1'b0, 1'b1);
    repeat (BRK + MK) tick();
    chk("hold1_valid", sel_valid, 1);
    chk("hold1_cur", cur_sel, 1);
    req1(1'b1, 1'b0);
    chk("roff_S", S, 0);
    chk("roff_valid", sel_valid, 0);
    chk("roff_ready", req_ready, 0);
    for (int i = 1; i < BRK; i++) begin
      tick();
      chk("roff_break_ready", req_ready, 0);
    end
    tick();
    chk("roff_off_ready", req_ready, 1);
    chk("roff_off_S", S, 0);
    req1(1'b0, 1'b0);
    chk("after_off_S", S, 2'b01);
    chk("after_off_ready", req_ready, 0);

    // Reset in the middle of MAKE
    repeat (3) tick();
    chk("mid_make_S", S, 2'b01);
    chk("mid_make_valid", sel_valid, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_S", S, 0);
    chk("mid_rst_valid", sel_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_cur", cur_sel, 0);
    rst = 1'b0;
    tick();

    // N_IN=3: out-of-range index in HOLD(2)
    req3(1'b0, 2'd2);
    repeat (MK) tick();
    chk("n3_hold_valid", sel3_valid, 1);
    chk("n3_hold_S", S3, 3'b100);
    req3(1'b0, 2'd3);
    chk("n3_bad_err", err3, 1);
    chk("n3_bad_S", S3, 3'b100);
    chk("n3_bad_valid", sel3_valid, 1);
    chk("n3_bad_cur", cur3_sel, 2);
    tick();
    chk("n3_err_pulse_end", err3, 0);
    chk("n3_after_S", S3, 3'b100);

    // Random request streams on both instances
    for (int c = 0; c < 10000; c++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_off    = ($urandom_range(0, 7) == 0);
      req_sel    = 1'($urandom_range(0, 1));
      req3_valid = 1'($urandom_range(0, 1));
      req3_off   = ($urandom_range(0, 7) == 0);
      req3_sel   = 2'($urandom_range(0, 3));
      e3 = req3_valid && req3_ready && !req3_off && (req3_sel == 2'd3);
      tick();
      chk("rand_err3", err3, e3);
      chk("rand_err2", err, 0);
    end
    req_valid = 1'b0;
    req3_valid = 1'b0;
    tick();

    chk("invariant_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
